rr_arbiter8: RTL and testbench

RR_ARBITER8 -- requirements
Module: rr_arbiter8

---
 rtl/rr_arbiter8.sv | 107 ++++++++++
 tb/tb_rr_arbiter8.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// rr_arbiter8 -- 8-way round-robin arbiter with a bounded grant hold time.
//
// A requester keeps the grant until it drops its request or has held it for
// MAX_HOLD cycles, after which the arbiter spends one idle GAP cycle and
// re-arbitrates starting just past the last winner. All outputs come
// straight from flops; nothing in REQ reaches an output combinationally.
//
// Ports:
//   clk    in   1  rising-edge clock
//   rst_n  in   1  asynchronous active-low reset
//   req    in   8  request lines, bit i = requester i wants the resource
//   gnt    out  8  one-hot grant (all zero when no grant is active)
//   gntId  out  3  index of the granted requester (0 when not busy)
//   busy   out  1  high while a grant is active
module rr_arbiter8 #(
    parameter int MAX_HOLD = 8          // legal range 1..15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gntId,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state, stateNext;
    logic [2:0] ptr, ptrNext;
    logic [3:0] cnt, cntNext;
    logic [2:0] idNext;
    logic [2:0] winner;
    logic       anyReq;
    logic       dropGrant;

    assign anyReq    = |req;
    // Holder leaves when it stops asking or has used up its hold budget.
    assign dropGrant = !req[gntId] || (cnt == 4'(MAX_HOLD));

    // First set request searching ptr, ptr+1, ... with 3-bit wrap. The loop
    // runs from the farthest offset down so the nearest hit is written last.
    always_comb begin
        winner = ptr;
        for (int i = 7; i >= 0; i--) begin
            if (req[ptr + 3'(i)]) winner = ptr + 3'(i);
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= 3'd0;
            cnt   <= 4'd0;
            gntId <= 3'd0;
            gnt   <= 8'h00;
            busy  <= 1'b0;
        end else begin
            state <= stateNext;
            ptr   <= ptrNext;
            cnt   <= cntNext;
            gntId <= idNext;
            gnt   <= (stateNext == GRANT) ? (8'b1 << idNext) : 8'h00;
            busy  <= (stateNext == GRANT);
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            GRANT:   stateNext = dropGrant ? GAP : GRANT;
            default: stateNext = anyReq ? GRANT : IDLE;   // IDLE and GAP
        endcase
    end

    // Next values for pointer, hold counter and granted index
    always_comb begin
        ptrNext = ptr;
        cntNext = cnt;
        idNext  = 3'd0;
        case (state)
            GRANT: begin
                if (dropGrant) begin
                    // Start the next search just past the holder so it
                    // goes to the back of the line.
                    ptrNext = gntId + 3'd1;
                    cntNext = 4'd0;
                end else begin
                    cntNext = cnt + 4'd1;
                    idNext  = gntId;
                end
            end
            default: begin
                if (anyReq) begin
                    idNext  = winner;
                    cntNext = 4'd1;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: four instances with MAX_HOLD = 2, 3, 4, 8 share one
// clock and reset. A cycle model predicts each instance's outputs; the
// prediction is queued when the requests are driven and compared after the
// following rising edge.
module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] reqA  [4];
    logic [7:0] gntA  [4];
    logic [2:0] idA   [4];
    logic       busyA [4];

    always #5 clk = ~clk;

    rr_arbiter8 #(.MAX_HOLD(2)) u2 (.clk(clk), .rst_n(rst_n), .req(reqA[0]),
        .gnt(gntA[0]), .gntId(idA[0]), .busy(busyA[0]));
    rr_arbiter8 #(.MAX_HOLD(3)) u3 (.clk(clk), .rst_n(rst_n), .req(reqA[1]),
        .gnt(gntA[1]), .gntId(idA[1]), .busy(busyA[1]));
    rr_arbiter8 #(.MAX_HOLD(4)) u4 (.clk(clk), .rst_n(rst_n), .req(reqA[2]),
        .gnt(gntA[2]), .gntId(idA[2]), .busy(busyA[2]));
    rr_arbiter8 #(.MAX_HOLD(8)) u8 (.clk(clk), .rst_n(rst_n), .req(reqA[3]),
        .gnt(gntA[3]), .gntId(idA[3]), .busy(busyA[3]));

    int nCmp = 0;
    int nBad = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        nCmp++;
        if (obs !== exp) begin
            nBad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model state, one entry per instance
    int  hold  [4] = '{2, 3, 4, 8};
    bit  mBusy [4];
    int  mId   [4];
    int  mPtr  [4];
    int  mCnt  [4];
    bit  prevB [4];
    int  order2[$];   // grant-start order seen on the MAX_HOLD=2 instance
    int  order3[$];   // grant-start order seen on the MAX_HOLD=3 instance

    typedef struct {
        int         inst;
        logic [7:0] g;
        logic [2:0] id;
        logic       b;
    } exp_t;
    exp_t sb[$];

    task automatic modelReset();
        for (int k = 0; k < 4; k++) begin
            mBusy[k] = 0; mId[k] = 0; mPtr[k] = 0; mCnt[k] = 0; prevB[k] = 0;
        end
    endtask

    // One clock edge of the model. An idle cycle (IDLE or GAP) always
    // arbitrates, so GAP needs no separate flag here.
    task automatic modelEdge(input int k, input logic [7:0] r);
        if (mBusy[k]) begin
            if (r[mId[k]] == 1'b0 || mCnt[k] == hold[k]) begin
                mBusy[k] = 0;
                mPtr[k]  = (mId[k] + 1) % 8;
            end else begin
                mCnt[k]++;
            end
        end else if (r != 8'h00) begin
            for (int s = 7; s >= 0; s--) begin
                if (r[(mPtr[k] + s) % 8]) mId[k] = (mPtr[k] + s) % 8;
            end
            mBusy[k] = 1;
            mCnt[k]  = 1;
        end
    endtask

    task automatic step(input logic [7:0] r0, input logic [7:0] r1,
                        input logic [7:0] r2, input logic [7:0] r3);
        exp_t e;
        reqA[0] = r0; reqA[1] = r1; reqA[2] = r2; reqA[3] = r3;
        for (int k = 0; k < 4; k++) begin
            modelEdge(k, reqA[k]);
            e.inst = k;
            e.b    = mBusy[k];
            e.id   = mBusy[k] ? 3'(mId[k]) : 3'd0;
            e.g    = mBusy[k] ? (8'b1 << mId[k]) : 8'h00;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("gnt[%0d]",  e.inst), gntA[e.inst],  e.g);
            chk($sformatf("id[%0d]",   e.inst), idA[e.inst],   e.id);
            chk($sformatf("busy[%0d]", e.inst), busyA[e.inst], e.b);
        end
        for (int k = 0; k < 4; k++) begin
            if (busyA[k] && !prevB[k]) begin
                if (k == 0) order2.push_back(idA[k]);
                if (k == 1) order3.push_back(idA[k]);
            end
            prevB[k] = busyA[k];
        end
    endtask

    initial begin
        int exp2[9];
        int exp3[4];
        exp2 = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
        exp3 = '{0, 7, 0, 7};
        for (int k = 0; k < 4; k++) reqA[k] = 8'hFF;   // requests ignored in reset
        modelReset();

        // Reset state, with requests asserted
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_gnt[%0d]", k),  gntA[k],  0);
            chk($sformatf("rst_id[%0d]", k),   idA[k],   0);
            chk($sformatf("rst_busy[%0d]", k), busyA[k], 0);
        end
        for (int k = 0; k < 4; k++) reqA[k] = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;

        // Basic grant and release on requester 0
        step(8'h00, 8'h00, 8'h00, 8'h01);
        chk("basic_gnt", gntA[3], 8'h01);
        step(8'h00, 8'h00, 8'h00, 8'h00);
        chk("basic_rel", busyA[3], 0);

        // Rotation with wrap: all request, hold 2
        repeat (27) step(8'hFF, 8'h00, 8'h00, 8'h00);
        step(8'h00, 8'h00, 8'h00, 8'h00);
        chk("rot_len", (order2.size() >= 9) ? 1 : 0, 1);
        if (order2.size() >= 9)
            for (int i = 0; i < 9; i++) chk($sformatf("rot_ord%0d", i), order2[i], exp2[i]);

        // Fairness between 0 and 7, hold 3
        repeat (16) step(8'h00, 8'h81, 8'h00, 8'h00);
        step(8'h00, 8'h00, 8'h00, 8'h00);
        chk("fair_len", (order3.size() >= 4) ? 1 : 0, 1);
        if (order3.size() >= 4)
            for (int i = 0; i < 4; i++) chk($sformatf("fair_ord%0d", i), order3[i], exp3[i]);

        // Forced release of a lone requester, hold 4, then re-grant
        repeat (8) step(8'h00, 8'h00, 8'h20, 8'h00);
        chk("force_regrant", gntA[2], 8'h20);
        step(8'h00, 8'h00, 8'h00, 8'h00);

        // Early release of 3 moves the pointer to 4, so 4 beats 3
        step(8'h00, 8'h00, 8'h00, 8'h08);
        step(8'h00, 8'h00, 8'h00, 8'h08);
        step(8'h00, 8'h00, 8'h00, 8'h00);
        chk("early_gap", gntA[3], 8'h00);
        step(8'h00, 8'h00, 8'h00, 8'h18);
        chk("early_ptr", idA[3], 4);
        // Non-granted bit toggling has no effect mid-grant
        step(8'h00, 8'h00, 8'h00, 8'h10);
        step(8'h00, 8'h00, 8'h00, 8'h18);
        chk("hold_id", idA[3], 4);

        // Asynchronous reset between edges, mid-grant
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", gntA[3], 0);
        chk("arst_busy", busyA[3], 0);
        chk("arst_id", idA[3], 0);
        modelReset();
        @(posedge clk);
        #1;
        chk("arst_hold", busyA[3], 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(8'h00, 8'h00, 8'h00, 8'h06);
        chk("arst_first", idA[3], 1);
        repeat (3) step(8'h00, 8'h00, 8'h00, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
